// File: rtl/data_cache_line_ctrl.sv
// Single-line write-back data cache between the core load/store port and the DDR burst interface.
// Serves hits in one cycle; on a miss, writes back a dirty line and then refills the new window.
module data_cache_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 28,
    parameter int DEPTH      = 16
) (
    input  logic                  rst,
    input  logic                  mem_clk,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_ack,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  ddr_rd_req,
    output logic [ADDR_WIDTH-1:0] ddr_rd_addr,
    output logic [9:0]            ddr_rd_len,
    input  logic                  ddr_rd_valid,
    input  logic [DATA_WIDTH-1:0] ddr_rd_data,
    input  logic                  ddr_rd_finish,
    output logic                  ddr_wr_req,
    output logic [ADDR_WIDTH-1:0] ddr_wr_addr,
    output logic [9:0]            ddr_wr_len,
    input  logic                  ddr_wr_data_req,
    output logic [DATA_WIDTH-1:0] ddr_wr_data,
    input  logic                  ddr_wr_finish
);
    localparam int OFF_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_WIDTH - OFF_W;
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, ACK, WB, FILL, FDONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] line [DEPTH];
    logic [TAG_W-1:0]      tag;
    logic                  valid, dirty, flush_pending;
    logic [CNT_W-1:0]      rcnt, wcnt;

    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] wr_idx;
    logic             hit, rd_take, hit_write;

    assign req_tag   = core_addr[ADDR_WIDTH-1:OFF_W];
    assign req_off   = core_addr[OFF_W-1:0];
    assign hit       = valid && (tag == req_tag);
    assign hit_write = (state == IDLE) && core_req && hit && core_we;
    assign rd_take   = (state == FILL) && ddr_rd_valid && (rcnt < CNT_FULL);
    // Once the whole line has been sent, extra data requests repeat the last word.
    assign wr_idx    = (wcnt == CNT_FULL) ? OFF_W'(DEPTH - 1) : wcnt[OFF_W-1:0];

    assign busy       = (state != IDLE);
    assign ddr_rd_len = 10'(DEPTH);
    assign ddr_wr_len = 10'(DEPTH);

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        core_ack   = 1'b0;
        flush_done = 1'b0;
        ddr_rd_req = 1'b0;
        ddr_wr_req = 1'b0;
        case (state)
            IDLE: begin
                // A pending core request always wins over flush.
                if (core_req) begin
                    if (hit)                state_nxt = ACK;
                    else if (valid && dirty) state_nxt = WB;
                    else                    state_nxt = FILL;
                end else if (flush) begin
                    state_nxt = dirty ? WB : FDONE;
                end
            end
            ACK: begin
                core_ack  = 1'b1;
                state_nxt = IDLE;
            end
            WB: begin
                ddr_wr_req = 1'b1;
                if (ddr_wr_finish) state_nxt = flush_pending ? FDONE : FILL;
            end
            FILL: begin
                ddr_rd_req = 1'b1;
                if (ddr_rd_finish) state_nxt = IDLE;
            end
            FDONE: begin
                flush_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            tag           <= '0;
            valid         <= 1'b0;
            dirty         <= 1'b0;
            flush_pending <= 1'b0;
            rcnt          <= '0;
            wcnt          <= '0;
            core_rdata    <= '0;
            ddr_wr_data   <= '0;
            ddr_rd_addr   <= '0;
            ddr_wr_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (hit) begin
                            if (core_we) dirty      <= 1'b1;
                            else         core_rdata <= line[req_off];
                        end else begin
                            ddr_wr_addr <= {tag, {OFF_W{1'b0}}};
                            ddr_rd_addr <= {req_tag, {OFF_W{1'b0}}};
                        end
                    end else if (flush && dirty) begin
                        flush_pending <= 1'b1;
                        ddr_wr_addr   <= {tag, {OFF_W{1'b0}}};
                    end
                end
                WB: begin
                    if (ddr_wr_data_req) begin
                        ddr_wr_data <= line[wr_idx];
                        if (wcnt != CNT_FULL) wcnt <= wcnt + 1'b1;
                    end
                    if (ddr_wr_finish) begin
                        dirty <= 1'b0;
                        wcnt  <= '0;
                    end
                end
                FILL: begin
                    if (rd_take) rcnt <= rcnt + 1'b1;
                    // The read base register holds the tag of the window being filled.
                    if (ddr_rd_finish) begin
                        tag   <= ddr_rd_addr[ADDR_WIDTH-1:OFF_W];
                        valid <= 1'b1;
                        dirty <= 1'b0;
                        rcnt  <= '0;
                    end
                end
                FDONE: flush_pending <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: the line storage has no reset; valid=0 after reset makes its contents unobservable,
    // and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge mem_clk) begin
        if (hit_write)    line[req_off]            <= core_wdata;
        else if (rd_take) line[rcnt[OFF_W-1:0]]    <= ddr_rd_data;
    end
endmodule

// File: tb/tb_data_cache_line_ctrl.sv
// Directed self-checking bench for data_cache_line_ctrl: hits, misses, write-back, flush,
// reset mid-fill and surplus read strobes, with hand-computed expectations.
module tb_data_cache_line_ctrl;
    logic        rst = 1'b1, mem_clk = 1'b0;
    logic        core_req = 0, core_we = 0, flush = 0;
    logic [27:0] core_addr = '0;
    logic [15:0] core_wdata = '0;
    logic        core_ack, flush_done, busy;
    logic [15:0] core_rdata;
    logic        ddr_rd_req, ddr_wr_req;
    logic [27:0] ddr_rd_addr, ddr_wr_addr;
    logic [9:0]  ddr_rd_len, ddr_wr_len;
    logic        ddr_rd_valid = 0, ddr_rd_finish = 0;
    logic [15:0] ddr_rd_data = '0;
    logic        ddr_wr_data_req = 0, ddr_wr_finish = 0;
    logic [15:0] ddr_wr_data;

    int checks = 0, failures = 0;
    int rd_bursts = 0, wr_bursts = 0, overlap = 0;
    logic prev_rd = 0, prev_wr = 0;
    logic [15:0] exp_line [16];

    data_cache_line_ctrl dut (
        .rst(rst), .mem_clk(mem_clk),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr), .ddr_rd_len(ddr_rd_len),
        .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data), .ddr_rd_finish(ddr_rd_finish),
        .ddr_wr_req(ddr_wr_req), .ddr_wr_addr(ddr_wr_addr), .ddr_wr_len(ddr_wr_len),
        .ddr_wr_data_req(ddr_wr_data_req), .ddr_wr_data(ddr_wr_data), .ddr_wr_finish(ddr_wr_finish)
    );

    always #5 mem_clk = ~mem_clk;

    // Burst counting on the falling edge, away from the active edge.
    always @(negedge mem_clk) begin
        if (ddr_rd_req && !prev_rd) rd_bursts++;
        if (ddr_wr_req && !prev_wr) wr_bursts++;
        if (ddr_rd_req && ddr_wr_req) overlap++;
        prev_rd = ddr_rd_req;
        prev_wr = ddr_wr_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge mem_clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [15:0] dbase, input bit fin_last);
        for (int i = 0; i < n; i++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = dbase + 16'(i);
            if (fin_last && i == n - 1) ddr_rd_finish = 1'b1;
            tick();
        end
        ddr_rd_valid = 1'b0;
        if (!fin_last) begin
            ddr_rd_finish = 1'b1;
            tick();
        end
        ddr_rd_finish = 1'b0;
    endtask

    task automatic wb(input string tag);
        for (int i = 0; i < 16; i++) begin
            ddr_wr_data_req = 1'b1;
            tick();
            check($sformatf("%s_w%0d", tag, i), 32'(ddr_wr_data), 32'(exp_line[i]));
        end
        ddr_wr_data_req = 1'b0;
        ddr_wr_finish   = 1'b1;
        tick();
        ddr_wr_finish = 1'b0;
    endtask

    task automatic hit_access(input string tag, input bit we, input logic [27:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp_rdata);
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        tick();
        check({tag, "_ack"}, 32'(core_ack), 32'd1);
        if (!we) check({tag, "_rdata"}, 32'(core_rdata), 32'(exp_rdata));
        check({tag, "_no_ddr"}, 32'({ddr_rd_req, ddr_wr_req}), 32'd0);
        core_req = 1'b0; core_we = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(core_ack), 32'd0);
    endtask

    initial begin
        tick(); tick();
        check("rst_outs", 32'({core_ack, flush_done, busy, ddr_rd_req, ddr_wr_req}), 32'd0);
        check("rst_rdata", 32'(core_rdata), 32'd0);
        check("rst_addrs", 32'(ddr_rd_addr | ddr_wr_addr), 32'd0);
        check("rd_len", 32'(ddr_rd_len), 32'd16);
        check("wr_len", 32'(ddr_wr_len), 32'd16);
        rst = 1'b0;
        tick();

        // Cold read of 0x45.
        core_req = 1'b1; core_we = 1'b0; core_addr = 28'h45;
        tick();
        check("s1_rd_req", 32'(ddr_rd_req), 32'd1);
        check("s1_rd_addr", 32'(ddr_rd_addr), 32'h40);
        check("s1_busy", 32'(busy), 32'd1);
        fill(16, 16'h1000, 1'b0);
        check("s1_ack_early", 32'(core_ack), 32'd0);
        check("s1_rd_req_drop", 32'(ddr_rd_req), 32'd0);
        tick();
        check("s1_ack", 32'(core_ack), 32'd1);
        check("s1_rdata", 32'(core_rdata), 32'h1005);
        core_req = 1'b0;
        tick();
        check("s1_bursts", 32'(rd_bursts), 32'd1);
        for (int i = 0; i < 16; i++) exp_line[i] = 16'h1000 + 16'(i);

        // Write hit then read hit.
        hit_access("s2_wr", 1'b1, 28'h47, 16'hBEEF, 16'h0);
        exp_line[7] = 16'hBEEF;
        hit_access("s2_rd", 1'b0, 28'h47, 16'h0, 16'hBEEF);

        // Dirty miss on 0x100.
        core_req = 1'b1; core_we = 1'b0; core_addr = 28'h100;
        tick();
        check("s3_wr_req", 32'(ddr_wr_req), 32'd1);
        check("s3_wr_addr", 32'(ddr_wr_addr), 32'h40);
        check("s3_rd_req_idle", 32'(ddr_rd_req), 32'd0);
        wb("s3");
        check("s3_wr_req_drop", 32'(ddr_wr_req), 32'd0);
        check("s3_rd_req", 32'(ddr_rd_req), 32'd1);
        check("s3_rd_addr", 32'(ddr_rd_addr), 32'h100);
        fill(16, 16'h2000, 1'b0);
        tick();
        check("s3_ack", 32'(core_ack), 32'd1);
        check("s3_rdata", 32'(core_rdata), 32'h2000);
        core_req = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) exp_line[i] = 16'h2000 + 16'(i);

        // Dirty flush.
        hit_access("s4_wr", 1'b1, 28'h103, 16'h1234, 16'h0);
        exp_line[3] = 16'h1234;
        flush = 1'b1;
        tick();
        check("s4_wr_req", 32'(ddr_wr_req), 32'd1);
        check("s4_wr_addr", 32'(ddr_wr_addr), 32'h100);
        wb("s4");
        check("s4_flush_done", 32'(flush_done), 32'd1);
        check("s4_no_fill", 32'(ddr_rd_req), 32'd0);
        flush = 1'b0;
        tick();
        check("s4_done_drop", 32'({flush_done, busy}), 32'd0);

        // Clean flush.
        flush = 1'b1;
        tick();
        check("s4c_flush_done", 32'(flush_done), 32'd1);
        check("s4c_no_ddr", 32'({ddr_rd_req, ddr_wr_req}), 32'd0);
        flush = 1'b0;
        tick();

        // Flush together with a request: the request goes first.
        flush = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 28'h105;
        tick();
        check("s4p_ack", 32'(core_ack), 32'd1);
        check("s4p_rdata", 32'(core_rdata), 32'h2005);
        check("s4p_done_early", 32'(flush_done), 32'd0);
        core_req = 1'b0;
        tick();
        check("s4p_done_wait", 32'(flush_done), 32'd0);
        tick();
        check("s4p_flush_done", 32'(flush_done), 32'd1);
        flush = 1'b0;
        tick();
        check("s4_wr_bursts", 32'(wr_bursts), 32'd2);

        // Reset mid-fill after 5 words.
        core_req = 1'b1; core_addr = 28'h300;
        tick();
        check("s5_rd_req", 32'(ddr_rd_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            ddr_rd_valid = 1'b1; ddr_rd_data = 16'h5000 + 16'(i);
            tick();
        end
        ddr_rd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("s5_rst_outs", 32'({core_ack, flush_done, busy, ddr_rd_req, ddr_wr_req}), 32'd0);
        check("s5_rst_addr", 32'(ddr_rd_addr), 32'd0);
        core_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Re-read 0x300: new burst; 18 strobes, last one with finish.
        core_req = 1'b1; core_addr = 28'h300;
        tick();
        check("s6_rd_req", 32'(ddr_rd_req), 32'd1);
        check("s6_rd_addr", 32'(ddr_rd_addr), 32'h300);
        fill(18, 16'h3000, 1'b1);
        tick();
        check("s6_ack", 32'(core_ack), 32'd1);
        check("s6_rdata0", 32'(core_rdata), 32'h3000);
        core_req = 1'b0;
        tick();
        hit_access("s6_rd15", 1'b0, 28'h30F, 16'h0, 16'h300F);
        hit_access("s6_rd1", 1'b0, 28'h301, 16'h0, 16'h3001);
        check("rd_bursts", 32'(rd_bursts), 32'd4);
        check("wr_bursts", 32'(wr_bursts), 32'd2);
        check("req_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
